rr_slot_scheduler: RTL and testbench

- Shares one resource (a bus or a counter datapath) among 4 requesters using round-robin arbitration with a bounded time slot per grant.
- A 2-bit wrapping priority pointer, a slot-length counter and a 3-state FSM sequence the grants.
- Sits between the requesting blocks and the shared resource. Drives a one-hot grant plus an encoded owner ID.

---
 rtl/rr_slot_scheduler_pkg.sv | 46 ++++
 rtl/rr_slot_scheduler_ptr_counter.sv | 28 ++
 rtl/rr_slot_scheduler.sv | 127 ++++++++++++
 tb/tb_rr_slot_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_slot_scheduler_pkg.sv
// Shared definitions for the round-robin slot scheduler: state encodings,
// requester count, pointer width and the rotating priority search.
package rr_slot_scheduler_pkg;

    localparam int NREQ  = 4;
    localparam int PTR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] id;
    } winner_t;

    // Rotating priority search starting at ptr. Offsets are scanned from the
    // highest down so the lowest offset with a request is the last write.
    function automatic winner_t find_winner(input logic [NREQ-1:0]  req,
                                            input logic [PTR_W-1:0] ptr);
        winner_t          w;
        logic [PTR_W-1:0] idx;
        w.found = 1'b0;
        w.id    = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + PTR_W'(i);
            if (req[idx]) begin
                w.found = 1'b1;
                w.id    = idx;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] id);
        logic [NREQ-1:0] one;
        one = 4'b0001;
        return one << id;
    endfunction

endpackage

// File: rtl/rr_slot_scheduler_ptr_counter.sv
// Round-robin priority pointer: 2-bit wrapping register that jumps to the
// slot just after the requester that was released.
module rr_ptr_counter
    import rr_slot_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [PTR_W-1:0] load_val,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_r;

    // Pointer register: on release, point one past the old owner (3 wraps to 0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= 2'd0;
        end else if (load_en) begin
            ptr_r <= load_val + 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/rr_slot_scheduler.sv
// Round-robin scheduler sharing one resource among four requesters. Each
// grant lasts until the owner drops its request or MAX_SLOT cycles elapse,
// and is always followed by a single dead GAP cycle.
module rr_slot_scheduler
    import rr_slot_scheduler_pkg::*;
#(
    parameter int MAX_SLOT = 8,
    parameter int SLOT_W   = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_id,
    output logic             grant_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAX_SLOT - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic [SLOT_W-1:0] slot_cnt_r;
    logic [NREQ-1:0]   grant_r;
    logic [PTR_W-1:0]  grant_id_r;
    logic              grant_valid_r;
    logic              timeout_r;
    logic              busy_r;

    logic [PTR_W-1:0]  ptr_s;
    logic              ptr_load_s;
    logic              start_s;
    logic              expire_s;
    winner_t           winner_s;

    assign winner_s = find_winner(req, ptr_s);

    rr_ptr_counter u_ptr (
        .clk      (clk),
        .reset    (reset),
        .load_en  (ptr_load_s),
        .load_val (grant_id_r),
        .ptr      (ptr_s)
    );

    // Next-state logic: start a grant from IDLE/GAP, release on drop or expiry.
    always_comb begin
        next_state_s = ST_IDLE;
        ptr_load_s   = 1'b0;
        start_s      = 1'b0;
        expire_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (enable && winner_s.found) begin
                    next_state_s = ST_GRANT;
                    start_s      = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[grant_id_r]) begin
                    // Owner let go; a drop on the expiry edge is still a normal release.
                    next_state_s = ST_GAP;
                    ptr_load_s   = 1'b1;
                end else if (slot_cnt_r == SLOT_LAST) begin
                    next_state_s = ST_GAP;
                    ptr_load_s   = 1'b1;
                    expire_s     = 1'b1;
                end else begin
                    next_state_s = ST_GRANT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs and slot counter, all aligned with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt_r    <= {SLOT_W{1'b0}};
            grant_r       <= 4'b0000;
            grant_id_r    <= 2'd0;
            grant_valid_r <= 1'b0;
            timeout_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            timeout_r     <= expire_s;
            busy_r        <= (next_state_s != ST_IDLE);
            grant_valid_r <= (next_state_s == ST_GRANT);
            if (start_s) begin
                slot_cnt_r <= {SLOT_W{1'b0}};
                grant_r    <= onehot(winner_s.id);
                grant_id_r <= winner_s.id;
            end else if (next_state_s == ST_GRANT) begin
                slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
                grant_r    <= grant_r;
                grant_id_r <= grant_id_r;
            end else begin
                slot_cnt_r <= slot_cnt_r;
                grant_r    <= 4'b0000;
                grant_id_r <= grant_id_r;
            end
        end
    end

    assign grant       = grant_r;
    assign grant_id    = grant_id_r;
    assign grant_valid = grant_valid_r;
    assign timeout     = timeout_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_rr_slot_scheduler.sv
// Self-checking bench for rr_slot_scheduler: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model that tracks owner, hold time and pointer as integers.
module tb_rr_slot_scheduler;

    localparam int MAXS = 8;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    rr_slot_scheduler #(.MAX_SLOT(MAXS), .SLOT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // owner = -1 when nobody holds the resource; held = cycles granted so far.
    typedef struct packed {
        int   owner;
        logic gap;
        int   ptr;
        int   held;
        logic to;
    } mstate_t;

    mstate_t ms = '{owner: -1, gap: 1'b0, ptr: 0, held: 0, to: 1'b0};

    function automatic int pick(input logic [3:0] r, input int p);
        logic [1:0] idx;
        for (int off = 0; off < 4; off++) begin
            idx = 2'((p + off) % 4);
            if (r[idx]) return int'(idx);
        end
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [3:0] r,
                                           input logic en);
        mstate_t    n;
        int         w;
        logic [1:0] o;
        n    = s;
        n.to = 1'b0;
        if (s.owner >= 0) begin
            o = s.owner[1:0];
            if (!r[o]) begin
                n.ptr = (s.owner + 1) % 4; n.owner = -1; n.gap = 1'b1;
            end else if (s.held == MAXS) begin
                n.ptr = (s.owner + 1) % 4; n.owner = -1; n.gap = 1'b1; n.to = 1'b1;
            end else begin
                n.held = s.held + 1;
            end
        end else begin
            n.gap = 1'b0;
            w = pick(r, s.ptr);
            if (en && w >= 0) begin
                n.owner = w; n.held = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) ms <= '{owner: -1, gap: 1'b0, ptr: 0, held: 0, to: 1'b0};
        else        ms <= model_next(ms, req, enable);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    logic [3:0] exp_grant;
    logic [3:0] one4 = 4'b0001;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            exp_grant = (ms.owner >= 0) ? (one4 << ms.owner) : 4'b0000;
            check("m_grant", int'(grant), int'(exp_grant));
            check("m_valid", int'(grant_valid), (ms.owner >= 0) ? 1 : 0);
            check("m_busy", int'(busy), (ms.owner >= 0 || ms.gap) ? 1 : 0);
            check("m_timeout", int'(timeout), int'(ms.to));
            if (ms.owner >= 0) check("m_grant_id", int'(grant_id), ms.owner);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req = 4'b0000; enable = 1'b1; reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; req = 4'b1111;
        #1 reset = 1'b0;
        check_en = 1'b1;

        // Reset held with all requests high: nothing granted.
        tick();
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout", int'(timeout), 0);
        reset = 1'b1;
        tick();
        check("first_grant", int'(grant), 1);
        check("first_id", int'(grant_id), 0);
        // All requests held: 8 grant cycles, then one GAP with timeout, period 9.
        for (int k = 1; k <= 44; k++) begin
            tick();
            exp_grant = (k % 9 < 8) ? (one4 << ((k / 9) % 4)) : 4'b0000;
            check("rot_grant", int'(grant), int'(exp_grant));
            check("rot_timeout", int'(timeout), (k % 9 == 8) ? 1 : 0);
        end

        // Single requester 2 dropping after 3 cycles, then pointer at 3.
        do_reset();
        req = 4'b0100;
        tick(); check("r2_g1", int'(grant), 4);
        tick(); check("r2_g2", int'(grant), 4);
        tick(); check("r2_g3", int'(grant), 4);
        req = 4'b0000;
        tick();
        check("r2_gap_grant", int'(grant), 0);
        check("r2_gap_busy", int'(busy), 1);
        check("r2_gap_to", int'(timeout), 0);
        tick(); check("r2_idle_busy", int'(busy), 0);
        req = 4'b1001;
        tick(); check("p3_grant", int'(grant), 8);
        repeat (7) tick();
        check("p3_last", int'(grant), 8);
        tick();
        check("p3_to_grant", int'(grant), 0);
        check("p3_to", int'(timeout), 1);
        tick();
        check("wrap_grant", int'(grant), 1);
        check("wrap_id", int'(grant_id), 0);
        req = 4'b1000;
        tick(); check("rel0_to", int'(timeout), 0);
        req = 4'b1001;
        tick(); check("p1_grant", int'(grant), 8);

        // enable dropped while requester 2 owns the resource.
        do_reset();
        req = 4'b1111;
        tick();
        repeat (20) tick();
        check("en_owner2", int'(grant), 4);
        check("en_id2", int'(grant_id), 2);
        enable = 1'b0;
        repeat (5) tick();
        check("en_finish", int'(grant), 4);
        tick(); check("en_to", int'(timeout), 1);
        tick(); check("en_idle_busy", int'(busy), 0);
        tick(); check("en_idle_grant", int'(grant), 0);
        enable = 1'b1;
        tick(); check("en_resume", int'(grant), 8);

        // Reset mid-grant (slot count 5): outputs clear without waiting for an edge.
        do_reset();
        req = 4'b1111;
        tick();
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("async_grant", int'(grant), 0);
        check("async_busy", int'(busy), 0);
        check("async_timeout", int'(timeout), 0);
        check("async_valid", int'(grant_valid), 0);
        tick();
        reset = 1'b1;
        tick();
        check("restart_grant", int'(grant), 1);

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
            end else begin
                reset = 1'b1;
            end
            if ((n / 500) % 2 == 0) begin
                if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            end else begin
                if ($urandom_range(0, 15) == 0) req = 4'($urandom_range(0, 15));
            end
            enable = ($urandom_range(0, 9) != 0);
        end

        tick();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
